lut_classifier: RTL and testbench
=================================

Name: lut_classifier

Overview:
- Parametrised, programmable successor to the team's fixed 4-bit-to-3-bit enable-gated classifier.
- The decode table is a runtime-writable register array of 2**IN_W entries, each OUT_W bits wide.
- Each lookup is registered and carries a valid flag.
- A saturating hit counter tracks how often a selectable class code is produced.
- Sits between the input-symbol source and downstream code consumers; software loads the table after reset.

Parameters:
- IN_W, 4, width of the lookup index (table depth = 2**IN_W).
- OUT_W, 3, width of each class code.
- CNT_W, 16, width of the hit counter.

Ports:
- clk  input  1  single clock, all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  lookup gate; when 0, a valid lookup returns code 0.
- in_valid  input  1  xin is valid this cycle.
- xin  input  IN_W  lookup index.
- wr_en  input  1  table write strobe.
- wr_addr  input  IN_W  table entry to write.
- wr_data  input  OUT_W  class code to store.
- lock  input  1  when 1, wr_en is ignored.
- cnt_sel  input  OUT_W  class code counted by hit_cnt.
- cnt_clr  input  1  clears hit_cnt.
- yout  output  OUT_W  registered class code.
- out_valid  output  1  yout is valid.
- hit_cnt  output  CNT_W  saturating count of valid outputs equal to cnt_sel.
- wr_err  output  1  one-cycle pulse when a write is attempted while lock=1.

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - All table entries become 0.
  - yout=0, out_valid=0, hit_cnt=0, wr_err=0.
  - Reset overrides every other input in the same cycle, including wr_en and in_valid.
- Table write:
  - If wr_en=1 and lock=0 at an edge, entry[wr_addr] <= wr_data.
  - If wr_en=1 and lock=1, the table is unchanged and wr_err=1 on the next cycle; otherwise wr_err=0.
- Lookup, latency 1:
  - If in_valid=1 at edge N, out_valid=1 during cycle N+1.
  - yout = entry[xin] when enable=1, and 0 when enable=0.
  - If in_valid=0, out_valid=0 next cycle and yout holds its last value.
- Read-during-write:
  - If the same edge has an unlocked write to address A and a lookup of A, yout returns the new wr_data (write-through bypass).
  - A lookup of any other address is unaffected by the write.
- Back-to-back lookups are supported at one per cycle with no bubbles.
- Hit counter:
  - Increments at edge N+1 when out_valid=1 and yout==cnt_sel, i.e. it counts registered outputs.
  - Saturates at 2**CNT_W-1 and never wraps.
  - cnt_clr=1 sets hit_cnt to 0 and takes priority over an increment in the same cycle.
  - Changing cnt_sel does not clear the count.
- Codes returned with enable=0 (always 0) are counted if cnt_sel==0.
- There is no sticky state beyond the table, yout, hit_cnt and wr_err.
- A reset mid-stream drops any in-flight lookup: out_valid is 0 in the cycle after reset.

Test Plan:
- Reset, then a lookup of xin=4'h5 with enable=1 -> out_valid=1 one cycle later, yout=0, hit_cnt=1 with cnt_sel=0.
- Write entries 0..15 with code (i mod 5), stream xin=0..15 back-to-back -> out_valid held high 16 cycles, yout matches i mod 5 each cycle, no bubbles.
- Write entry 4'h3=3'b110 and look up 4'h3 on the same edge -> yout=3'b110 next cycle; a lookup of 4'h2 on that edge returns the old entry.
- lock=1, wr_en=1, wr_addr=4'h7, wr_data=3'b111 -> wr_err pulses 1 cycle, and a later lookup of 4'h7 returns the unchanged value.
- enable=0 with in_valid=1 across table entries holding 3'b100 -> yout=0, out_valid=1, and hit_cnt increments only when cnt_sel=0.
- Hit counter:
  - With CNT_W=4, 20 matching lookups -> hit_cnt saturates at 15.
  - cnt_clr together with a match -> hit_cnt=0.
  - Reset asserted mid-stream -> out_valid=0 and hit_cnt=0 the next cycle.

Source files
------------

// File: rtl/lut_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : lut_classifier
//  Brief    : Programmable lookup-table classifier. Maps an IN_W-bit symbol
//             to an OUT_W-bit class code through a runtime-writable table.
//             Lookups are registered with a valid flag. A saturating counter
//             tallies registered outputs that match a selectable class code.
//  Revision : 1.0 - initial release
// ============================================================================
module lut_classifier #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  xin,
    input  logic             wr_en,
    input  logic [IN_W-1:0]  wr_addr,
    input  logic [OUT_W-1:0] wr_data,
    input  logic             lock,
    input  logic [OUT_W-1:0] cnt_sel,
    input  logic             cnt_clr,
    output logic [OUT_W-1:0] yout,
    output logic             out_valid,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             wr_err
);

    localparam int             c_depth   = 2 ** IN_W;
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [OUT_W-1:0] r_table [0:c_depth-1];
    logic [OUT_W-1:0] r_yout;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_hit_cnt;
    logic             r_wr_err;

    logic             w_wr_ok;
    logic [OUT_W-1:0] w_lookup;
    logic             w_hit;

    // A write only lands when the table is unlocked.
    assign w_wr_ok = wr_en & ~lock;

    // Write-through bypass: a lookup of the address being written this edge
    // sees the new data rather than the stale entry.
    always_comb begin
        w_lookup = r_table[xin];
        if (w_wr_ok && (wr_addr == xin)) begin
            w_lookup = wr_data;
        end
    end

    // The counter watches registered outputs, so it lags a lookup by one edge.
    assign w_hit = r_out_valid && (r_yout == cnt_sel);

    // Table storage, registered lookup result and locked-write error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_depth; i++) begin
                r_table[i] <= '0;
            end
            r_yout      <= '0;
            r_out_valid <= 1'b0;
            r_wr_err    <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_table[wr_addr] <= wr_data;
            end
            r_wr_err    <= wr_en & lock;
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_yout <= enable ? w_lookup : '0;
            end
        end
    end

    // Saturating hit counter; clear beats increment in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_cnt <= '0;
        end else if (cnt_clr) begin
            r_hit_cnt <= '0;
        end else if (w_hit && (r_hit_cnt != c_cnt_max)) begin
            r_hit_cnt <= r_hit_cnt + 1'b1;
        end
    end

    assign yout      = r_yout;
    assign out_valid = r_out_valid;
    assign hit_cnt   = r_hit_cnt;
    assign wr_err    = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_lut_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lut_classifier
//  Brief    : Directed self-checking bench for lut_classifier (CNT_W=4 so
//             that counter saturation is reached quickly).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lut_classifier;

    localparam int IN_W  = 4;
    localparam int OUT_W = 3;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             in_valid;
    logic [IN_W-1:0]  xin;
    logic             wr_en;
    logic [IN_W-1:0]  wr_addr;
    logic [OUT_W-1:0] wr_data;
    logic             lock;
    logic [OUT_W-1:0] cnt_sel;
    logic             cnt_clr;
    logic [OUT_W-1:0] yout;
    logic             out_valid;
    logic [CNT_W-1:0] hit_cnt;
    logic             wr_err;

    int n_checks = 0;
    int n_errors = 0;

    lut_classifier #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in_valid  (in_valid),
        .xin       (xin),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .lock      (lock),
        .cnt_sel   (cnt_sel),
        .cnt_clr   (cnt_clr),
        .yout      (yout),
        .out_valid (out_valid),
        .hit_cnt   (hit_cnt),
        .wr_err    (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and tally it.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled off-edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        xin      = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        lock     = 1'b0;
        cnt_sel  = '0;
        cnt_clr  = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_yout",   yout,      0);
        check("rst_valid",  out_valid, 0);
        check("rst_hit",    hit_cnt,   0);
        check("rst_wr_err", wr_err,    0);

        // First lookup after reset returns cleared entry, counted when cnt_sel=0
        enable = 1'b1; in_valid = 1'b1; xin = 4'h5; cnt_sel = 3'd0;
        tick();
        check("first_valid", out_valid, 1);
        check("first_yout",  yout,      0);
        in_valid = 1'b0;
        tick();
        check("first_hit",   hit_cnt,   1);
        check("first_drop",  out_valid, 0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_hit", hit_cnt, 0);

        // Load entries with i mod 5, then stream every index back-to-back
        cnt_sel = 3'd7;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = i[IN_W-1:0]; wr_data = 3'(i % 5);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; xin = i[IN_W-1:0];
            tick();
            check($sformatf("stream_valid_%0d", i), out_valid, 1);
            check($sformatf("stream_yout_%0d", i),  yout,      i % 5);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_valid", out_valid, 0);

        // Write-through bypass on the same address
        wr_en = 1'b1; wr_addr = 4'h3; wr_data = 3'b110;
        in_valid = 1'b1; xin = 4'h3;
        tick();
        check("bypass_yout", yout, 3'b110);
        wr_en = 1'b0;
        tick();
        check("bypass_stored", yout, 3'b110);
        // Write to 3 while looking up 2: lookup sees the old entry of 2
        wr_en = 1'b1; wr_addr = 4'h3; wr_data = 3'b101; xin = 4'h2;
        tick();
        check("other_addr_yout", yout, 2);
        wr_en = 1'b0; in_valid = 1'b0;
        tick();
        check("hold_yout",  yout,      2);
        check("hold_valid", out_valid, 0);

        // Locked write: error pulse, table unchanged, no bypass
        lock = 1'b1; wr_en = 1'b1; wr_addr = 4'h7; wr_data = 3'b111;
        in_valid = 1'b1; xin = 4'h7;
        tick();
        check("lock_err",  wr_err, 1);
        check("lock_yout", yout,   2);
        lock = 1'b0; wr_en = 1'b0; in_valid = 1'b0;
        tick();
        check("lock_err_pulse", wr_err, 0);
        in_valid = 1'b1; xin = 4'h7;
        tick();
        check("lock_unchanged", yout, 2);
        in_valid = 1'b0;

        // Entries 8,9 hold 3'b100; enable=0 forces code 0
        wr_en = 1'b1; wr_addr = 4'h8; wr_data = 3'b100;
        tick();
        wr_addr = 4'h9;
        tick();
        wr_en = 1'b0; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        cnt_sel = 3'b100; enable = 1'b0; in_valid = 1'b1; xin = 4'h8;
        tick();
        check("dis_yout_8",  yout,      0);
        check("dis_valid_8", out_valid, 1);
        xin = 4'h9;
        tick();
        check("dis_yout_9",  yout,      0);
        in_valid = 1'b0;
        tick();
        tick();
        check("dis_hit_sel4", hit_cnt, 0);
        cnt_sel = 3'd0; in_valid = 1'b1; xin = 4'h8;
        tick();
        xin = 4'h9;
        tick();
        in_valid = 1'b0;
        tick();
        check("dis_hit_sel0", hit_cnt, 2);
        // Enabled lookup yields 4, not counted with cnt_sel=0
        enable = 1'b1; in_valid = 1'b1; xin = 4'h8;
        tick();
        check("en_yout_8", yout, 3'b100);
        in_valid = 1'b0;
        tick();
        check("en_no_count", hit_cnt, 2);
        cnt_sel = 3'b100;
        tick();
        check("sel_change_keeps", hit_cnt, 2);

        // Saturation: 20 matching outputs on a 4-bit counter
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        in_valid = 1'b1; xin = 4'h8;
        for (int i = 0; i < 20; i++) tick();
        in_valid = 1'b0;
        tick();
        check("sat_hit", hit_cnt, 15);
        tick();
        check("sat_hold", hit_cnt, 15);

        // Clear wins over a simultaneous match
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        in_valid = 1'b1; xin = 4'h8;
        tick();
        check("clr_pre_match", yout, 3'b100);
        in_valid = 1'b0; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_beats_inc", hit_cnt, 0);

        // Reset mid-stream overrides lookup, write and count
        in_valid = 1'b1; xin = 4'h8;
        tick();
        check("pre_rst_valid", out_valid, 1);
        reset = 1'b1; wr_en = 1'b1; wr_addr = 4'h8; wr_data = 3'b001;
        tick();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_hit",   hit_cnt,   0);
        check("mid_rst_yout",  yout,      0);
        reset = 1'b0; wr_en = 1'b0;
        tick();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_table", yout,      0);
        in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
